// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache memory arbiter.
package cache_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_RESP
  } arb_state_t;

  localparam int LINE_WORDS = 8;
  localparam int BEAT_W     = $clog2(LINE_WORDS);
  localparam int OFF        = BEAT_W + 2;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port
// that was not granted last time.
module rr_grant2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_o,
  output logic       any_o
);

  // Combinational winner selection.
  always_comb begin
    any_o = |req_i;
    gnt_o = 1'b0;
    if (&req_i) begin
      gnt_o = ~last_gnt_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one single-word memory port between the I-cache (port 0) and the
// D-cache (port 1). A granted line is moved as LINE_WORDS memory beats and
// completes with a one-cycle resp pulse (plus err if a beat timed out).
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [1:0]                     req_i,
  input  logic [1:0]                     we_i,
  input  logic [2*ADDR_W-1:0]            addr_i,
  input  logic [2*LINE_WORDS*WORD_W-1:0] wline_i,
  output logic [LINE_WORDS*WORD_W-1:0]   rline_o,
  output logic [1:0]                     resp_o,
  output logic [1:0]                     err_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  output logic [WORD_W-1:0]              mem_wdata_o,
  input  logic [WORD_W-1:0]              mem_rdata_i,
  input  logic                           mem_ack_i
);

  import cache_pkg::*;

  localparam int BW   = $clog2(LINE_WORDS);
  localparam int OFFS = BW + 2;
  localparam int LA   = ADDR_W - OFFS;
  localparam int WCW  = $clog2(TIMEOUT);

  arb_state_t                  state_q, state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [WCW-1:0]              wait_q, wait_d;
  logic                        last_gnt_q, last_gnt_d;
  logic                        gnt_q, gnt_d;
  logic                        abort_q, abort_d;
  logic                        we_q, we_d;
  logic [LA-1:0]               line_q, line_d;
  logic [LINE_WORDS*WORD_W-1:0] rline_q, rline_d;

  logic pick;
  logic any_req;
  logic in_xfer;
  logic ack;

  // Byte-offset bits of the request addresses are meaningless for a line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[OFFS-1:0], addr_i[ADDR_W+OFFS-1:ADDR_W]};

  rr_grant2 u_rr (
    .req_i      (req_i),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick),
    .any_o      (any_req)
  );

  assign in_xfer = (state_q == ARB_XFER);
  // Acks outside a transfer are ignored entirely.
  assign ack     = mem_ack_i & in_xfer;

  // Next-state logic for the line sequencer and fill buffer.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    abort_d    = abort_q;
    we_d       = we_q;
    line_d     = line_q;
    rline_d    = rline_q;
    case (state_q)
      ARB_IDLE: begin
        beat_d  = '0;
        wait_d  = '0;
        abort_d = 1'b0;
        if (any_req) begin
          state_d    = ARB_XFER;
          gnt_d      = pick;
          last_gnt_d = pick;
          we_d       = we_i[pick];
          line_d     = pick ? addr_i[2*ADDR_W-1 -: LA] : addr_i[ADDR_W-1 -: LA];
        end
      end
      ARB_XFER: begin
        if (ack) begin
          if (!we_q) begin
            rline_d[int'(beat_q)*WORD_W +: WORD_W] = mem_rdata_i;
          end
          wait_d = '0;
          if (beat_q == BW'(LINE_WORDS - 1)) begin
            state_d = ARB_RESP;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (wait_q == WCW'(TIMEOUT - 1)) begin
          state_d = ARB_RESP;
          abort_d = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Control state and fill buffer; reset aborts any line in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      beat_q     <= '0;
      wait_q     <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      abort_q    <= 1'b0;
      rline_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      abort_q    <= abort_d;
      rline_q    <= rline_d;
    end
  end

  // Latched request attributes; only observed while a line is in flight.
  always_ff @(posedge clk_i) begin
    we_q   <= we_d;
    line_q <= line_d;
  end

  // Memory-side beat outputs, forced to zero outside a transfer.
  always_comb begin
    mem_req_o   = in_xfer;
    mem_we_o    = in_xfer & we_q;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (in_xfer) begin
      mem_addr_o  = {line_q, beat_q, 2'b00};
      mem_wdata_o = wline_i[(int'(gnt_q)*LINE_WORDS + int'(beat_q))*WORD_W +: WORD_W];
    end
  end

  assign resp_o  = (state_q == ARB_RESP) ? {gnt_q, ~gnt_q} : 2'b00;
  assign err_o   = resp_o & {2{abort_q}};
  assign rline_o = rline_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with random
// data, checked against a line-level reference model.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 8;
  localparam int TO = 64;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [1:0]             req;
  logic [1:0]             we;
  logic [31:0]            pa [2];
  logic [31:0]            wl [2][LW];
  logic [2*AW-1:0]        addr_flat;
  logic [2*LW*WW-1:0]     wline_flat;
  logic [LW*WW-1:0]       rline;
  logic [1:0]             resp;
  logic [1:0]             err;
  logic                   mem_req;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [WW-1:0]          mem_wdata;
  logic [WW-1:0]          mem_rdata;
  logic                   mem_ack;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  int last_win;
  logic [31:0] exp_rl [LW];

  always #5 clk = ~clk;

  assign addr_flat = {pa[1], pa[0]};

  always_comb begin
    wline_flat = '0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < LW; k++)
        wline_flat[(p*LW + k)*WW +: WW] = wl[p][k];
  end

  cache_mem_arbiter #(
    .ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW), .TIMEOUT(TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr_flat),
    .wline_i     (wline_flat),
    .rline_o     (rline),
    .resp_o      (resp),
    .err_o       (err),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_flat();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < LW; k++) f[k*WW +: WW] = exp_rl[k];
    return f;
  endfunction

  // Round-robin reference: sole requester wins, a tie goes away from the last winner.
  function automatic int rr_pick(input logic [1:0] r);
    int w;
    if (r == 2'b11) w = 1 - last_win;
    else            w = r[1] ? 1 : 0;
    last_win = w;
    return w;
  endfunction

  // Serve one line for 'port' (its req already raised) and check it beat by beat.
  task automatic run_line(input int port, input int ack_mod, input bit rnd_rd, input bit no_ack);
    logic [31:0] line;
    bit   wr;
    bit   done;
    int   beat, acks, cyc, start, last_ack;
    wr = we[port];
    line = (pa[port] >> 5) << 5;
    done = 0; beat = 0; acks = 0; cyc = 0; start = 0; last_ack = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (resp != 2'b00) begin
        done = 1;
        chk("resp_port", resp, (port == 1) ? 2'b10 : 2'b01);
        chk("err", err, no_ack ? ((port == 1) ? 2'b10 : 2'b01) : 2'b00);
        chk("mem_req_in_resp", mem_req, 0);
        chk("rline", rline, exp_flat());
        if (no_ack) chk("timeout_lat", cyc - start, TO);
        else begin
          chk("ack_count", acks, LW);
          chk("resp_lat", cyc - last_ack, 1);
        end
        req[port] = 1'b0;
      end else if (mem_req) begin
        if (start == 0) begin
          start = cyc;
          chk("start_lat", cyc, 1);
          pa[port] = $urandom;
        end
        chk("mem_addr", mem_addr, line + 32'(beat*4));
        chk("mem_we", mem_we, wr);
        if (wr && beat < LW) chk("mem_wdata", mem_wdata, wl[port][beat]);
        if (!no_ack && beat < LW && (cyc % ack_mod) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = rnd_rd ? $urandom : 32'hA0 + 32'(beat);
          if (!wr) exp_rl[beat] = mem_rdata;
          beat++;
          acks++;
          last_ack = cyc;
        end
      end
    end
    if (!done) chk("resp_seen", 0, 1);
    @(negedge clk);
    chk("resp_one_cycle", resp, 0);
    chk("mem_req_after", mem_req, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    bit hit;
    int n;
    rst_n = 1'b0; req = 2'b00; we = 2'b00; mem_ack = 1'b0; mem_rdata = '0;
    pa[0] = '0; pa[1] = '0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < LW; k++) wl[p][k] = $urandom;
    for (int k = 0; k < LW; k++) exp_rl[k] = '0;
    last_win = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_resp", resp, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rline", rline, 0);

    // Port 0 fill of line 0x1040, ack every cycle, rdata = 0xA0 + beat.
    pa[0] = 32'h0000_1040; we[0] = 1'b0; req[0] = 1'b1;
    w = rr_pick(req);
    run_line(w, 1, 0, 0);
    chk("t1_rline_w7", rline[255:224], 32'hA7);

    // Port 1 writeback of 0x2000, words 0x11*k, ack every third cycle.
    for (int k = 0; k < LW; k++) wl[1][k] = 32'h11 * k;
    pa[1] = 32'h0000_2000; we[1] = 1'b1; req[1] = 1'b1;
    w = rr_pick(req);
    run_line(w, 3, 1, 0);

    // Simultaneous requests after a fresh reset: port 0 first, then port 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; last_win = 1;
    for (int k = 0; k < LW; k++) exp_rl[k] = '0;
    for (int k = 0; k < LW; k++) begin wl[0][k] = $urandom; wl[1][k] = $urandom; end
    pa[0] = 32'h0000_3007; we[0] = 1'b1;
    pa[1] = 32'h0000_5F3C; we[1] = 1'b0;
    req = 2'b11;
    w = rr_pick(req);
    run_line(w, 1, 1, 0);
    w = rr_pick(req);
    run_line(w, 2, 1, 0);

    // Port 0 alone, then a tie: port 1 must win this time, then port 0.
    pa[0] = 32'h0001_0080; we[0] = 1'b0; req[0] = 1'b1;
    w = rr_pick(req);
    run_line(w, 1, 1, 0);
    pa[0] = 32'h0002_00A0; we[0] = 1'b0;
    pa[1] = 32'h0003_00C0; we[1] = 1'b1;
    req = 2'b11;
    w = rr_pick(req);
    chk("t3_tie_winner", w, 1);
    run_line(w, 1, 1, 0);
    w = rr_pick(req);
    run_line(w, 1, 1, 0);

    // Spurious acks while idle are ignored; the next fill still takes 8 beats from beat 0.
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_ack_mem_req", mem_req, 0);
      chk("idle_ack_resp", resp, 0);
    end
    pa[0] = 32'h0000_7700; we[0] = 1'b0; req[0] = 1'b1;
    w = rr_pick(req);
    run_line(w, 1, 1, 0);

    // Port 1 fill with no acks: aborts with err after TIMEOUT cycles, rline kept.
    pa[1] = 32'h0000_9900; we[1] = 1'b0; req[1] = 1'b1;
    w = rr_pick(req);
    run_line(w, 1, 1, 1);

    // Reset during beat 4 of a port 0 fill, then restart from beat 0.
    pa[0] = 32'h0000_4A60; we[0] = 1'b0; req[0] = 1'b1;
    hit = 0; n = 0;
    while (!hit && n < 20) begin
      @(negedge clk);
      n++;
      mem_ack = 1'b0;
      if (mem_req && mem_addr == 32'h0000_4A70) hit = 1;
      else if (mem_req) begin mem_ack = 1'b1; mem_rdata = $urandom; end
    end
    chk("t6_reached_beat4", hit, 1);
    mem_ack = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_resp", resp, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_mem_req", mem_req, 0);
    chk("t6_rst_mem_we", mem_we, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_mem_wdata", mem_wdata, 0);
    chk("t6_rst_rline", rline, 0);
    rst_n = 1'b1; last_win = 1;
    for (int k = 0; k < LW; k++) exp_rl[k] = '0;
    w = rr_pick(req);
    run_line(w, 1, 1, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
